// File: rtl/ts_rec_frame_aggr.sv
// ts_rec_frame_aggr
//   Packs 33-bit TS records (4 header words + PAY_WORDS payload words) that
//   share a destination (gbe, ip, port) into one bank of a ping-pong buffer.
//   Each closed bank is emitted as one frame: D0, D1, then the payload.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   rec_din_en    input word valid (no backpressure)
//   rec_din       bit32 = record start, [31:0] = word
//   out_rdy       downstream accepts the presented word
//   out_valid     output word valid
//   out_data      output word
//   out_sof       marks descriptor D0
//   out_eof       marks the last payload word
//   drop_cnt      records dropped because no bank was free (saturating)
//   err_cnt       framing errors (saturating)
// Handshake: a word moves when out_valid && out_rdy; while out_valid is high
// and out_rdy is low, out_data/out_sof/out_eof stay unchanged.
module ts_rec_frame_aggr #(
  parameter int TS_PER_FRAME = 7,
  parameter int PAY_WORDS    = 47,
  parameter int TIMEOUT      = 4096,
  parameter int ADDR_W       = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_din_en,
  input  logic [32:0] rec_din,
  input  logic        out_rdy,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt
);
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int PIDX_W = $clog2(PAY_WORDS + 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT);
  localparam logic [3:0]        TS_MAX    = 4'(TS_PER_FRAME);
  localparam logic [PIDX_W-1:0] PIDX_LAST = PIDX_W'(PAY_WORDS - 1);

  typedef enum logic [1:0] {IN_IDLE = 2'd0, IN_HDR = 2'd1, IN_PAY = 2'd2} in_st_e;
  typedef enum logic [1:0] {OUT_IDLE = 2'd0, OUT_D0 = 2'd1, OUT_D1 = 2'd2, OUT_PAY = 2'd3} out_st_e;

  // input side
  in_st_e              in_st_q, in_st_d;
  logic [1:0]          hdr_cnt_q, hdr_cnt_d;
  logic [7:0]          gbe_q, gbe_d;
  logic [31:0]         ip_q, ip_d;
  logic [PIDX_W-1:0]   pay_idx_q, pay_idx_d;
  logic                rec_bank_q, rec_bank_d;
  logic [ADDR_W-1:0]   rec_base_q, rec_base_d;
  logic                rec_drop_q, rec_drop_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [15:0]         drop_q, drop_d, err_q, err_d;
  // bank bookkeeping; owned = bank handed to the output side
  logic                fill_q, fill_d;
  logic [1:0]          owned_q, owned_d;
  logic [3:0]          ts_q [2];
  logic [3:0]          ts_d [2];
  logic [7:0]          dgbe_q [2];
  logic [7:0]          dgbe_d [2];
  logic [31:0]         dip_q [2];
  logic [31:0]         dip_d [2];
  logic [15:0]         dport_q [2];
  logic [15:0]         dport_d [2];
  // output side
  out_st_e             out_st_q, out_st_d;
  logic                out_bank_q, out_bank_d;
  logic [ADDR_W-1:0]   rd_idx_q, rd_idx_d;
  logic [31:0]         rd_data_q;
  // buffer ports
  logic [31:0]         mem_q [2**(ADDR_W+1)];
  logic                mem_we, rd_en, rel;
  logic [ADDR_W:0]     mem_waddr, rd_addr;
  logic [31:0]         mem_wdata;
  logic                pay_last;
  // destination-check scratch
  logic                fb_c, same_c, adopt_c, drop_c;
  logic [1:0]          owned_a_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_st_q    <= IN_IDLE;
      hdr_cnt_q  <= '0;
      gbe_q      <= '0;
      ip_q       <= '0;
      pay_idx_q  <= '0;
      rec_bank_q <= 1'b0;
      rec_base_q <= '0;
      rec_drop_q <= 1'b0;
      tmo_q      <= '0;
      drop_q     <= '0;
      err_q      <= '0;
      fill_q     <= 1'b0;
      owned_q    <= '0;
      for (int b = 0; b < 2; b++) begin
        ts_q[b]    <= '0;
        dgbe_q[b]  <= '0;
        dip_q[b]   <= '0;
        dport_q[b] <= '0;
      end
      out_st_q   <= OUT_IDLE;
      out_bank_q <= 1'b0;
      rd_idx_q   <= '0;
    end else begin
      in_st_q    <= in_st_d;
      hdr_cnt_q  <= hdr_cnt_d;
      gbe_q      <= gbe_d;
      ip_q       <= ip_d;
      pay_idx_q  <= pay_idx_d;
      rec_bank_q <= rec_bank_d;
      rec_base_q <= rec_base_d;
      rec_drop_q <= rec_drop_d;
      tmo_q      <= tmo_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
      fill_q     <= fill_d;
      owned_q    <= owned_d;
      ts_q       <= ts_d;
      dgbe_q     <= dgbe_d;
      dip_q      <= dip_d;
      dport_q    <= dport_d;
      out_st_q   <= out_st_d;
      out_bank_q <= out_bank_d;
      rd_idx_q   <= rd_idx_d;
    end
  end

  // Frame buffer: one write port (fill side), one registered read port.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (rd_en)  rd_data_q <= mem_q[rd_addr];
  end

  // Input FSM and bank management
  always_comb begin
    in_st_d    = in_st_q;
    hdr_cnt_d  = hdr_cnt_q;
    gbe_d      = gbe_q;
    ip_d       = ip_q;
    pay_idx_d  = pay_idx_q;
    rec_bank_d = rec_bank_q;
    rec_base_d = rec_base_q;
    rec_drop_d = rec_drop_q;
    drop_d     = drop_q;
    err_d      = err_q;
    fill_d     = fill_q;
    owned_d    = owned_q;
    ts_d       = ts_q;
    dgbe_d     = dgbe_q;
    dip_d      = dip_q;
    dport_d    = dport_q;
    tmo_d      = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
    mem_we     = 1'b0;
    mem_waddr  = {rec_bank_q, rec_base_q + ADDR_W'(pay_idx_q)};
    mem_wdata  = rec_din[31:0];
    fb_c       = fill_q;
    owned_a_c  = owned_q;
    same_c     = 1'b0;
    adopt_c    = 1'b0;
    drop_c     = 1'b0;

    // The bank becomes refillable the cycle after its eof transfer.
    if (rel) begin
      owned_d[out_bank_q] = 1'b0;
      ts_d[out_bank_q]    = '0;
    end

    // Full or timed-out fill bank closes first; a W3 in this same cycle then
    // sees the other bank. Header words never touch the bank, so a timeout
    // may close it while a header is still arriving.
    if (!owned_q[fill_q] && ts_q[fill_q] != 4'd0 &&
        (ts_q[fill_q] == TS_MAX || (tmo_q == TMO_MAX && in_st_q != IN_PAY))) begin
      owned_a_c[fill_q] = 1'b1;
      owned_d[fill_q]   = 1'b1;
      fb_c              = ~fill_q;
      fill_d            = ~fill_q;
    end

    case (in_st_q)
      IN_IDLE: begin
        if (rec_din_en && rec_din[32]) begin
          in_st_d   = IN_HDR;
          hdr_cnt_d = 2'd1;
        end else if (rec_din_en) begin
          if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
        end
      end
      IN_HDR: begin
        if (rec_din_en && rec_din[32]) begin
          if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
          hdr_cnt_d = 2'd1;
        end else if (rec_din_en) begin
          case (hdr_cnt_q)
            2'd1: begin
              gbe_d     = rec_din[7:0];
              hdr_cnt_d = 2'd2;
            end
            2'd2: begin
              ip_d      = rec_din[31:0];
              hdr_cnt_d = 2'd3;
            end
            2'd3: begin
              same_c = (dgbe_q[fb_c] == gbe_q) && (dip_q[fb_c] == ip_q) &&
                       (dport_q[fb_c] == rec_din[15:0]);
              if (owned_a_c[fb_c]) begin
                drop_c = 1'b1;
              end else if (ts_q[fb_c] == 4'd0) begin
                adopt_c = 1'b1;
              end else if (!same_c) begin
                // destination change: close this bank, move to the other
                owned_d[fb_c] = 1'b1;
                fb_c          = ~fb_c;
                fill_d        = fb_c;
                if (owned_a_c[fb_c]) drop_c = 1'b1;
                else                 adopt_c = 1'b1;
              end
              if (adopt_c) begin
                dgbe_d[fb_c]  = gbe_q;
                dip_d[fb_c]   = ip_q;
                dport_d[fb_c] = rec_din[15:0];
              end
              if (drop_c && drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
              rec_bank_d = fb_c;
              rec_base_d = ADDR_W'(32'(ts_q[fb_c]) * PAY_WORDS);
              rec_drop_d = drop_c;
              pay_idx_d  = '0;
              hdr_cnt_d  = 2'd0;
              in_st_d    = IN_PAY;
            end
            default: hdr_cnt_d = 2'd0;
          endcase
        end
      end
      IN_PAY: begin
        if (rec_din_en && rec_din[32]) begin
          // abort: nothing committed, so the bank is untouched
          if (err_q != 16'hFFFF) err_d = err_q + 1'b1;
          hdr_cnt_d = 2'd1;
          in_st_d   = IN_HDR;
        end else if (rec_din_en) begin
          mem_we = !rec_drop_q;
          if (pay_idx_q == PIDX_LAST) begin
            in_st_d = IN_IDLE;
            if (!rec_drop_q) begin
              ts_d[rec_bank_q] = ts_q[rec_bank_q] + 1'b1;
              tmo_d            = '0;
            end
          end else begin
            pay_idx_d = pay_idx_q + 1'b1;
          end
        end
      end
      default: in_st_d = IN_IDLE;
    endcase
  end

  assign pay_last = (rd_idx_q == ADDR_W'(32'(ts_q[out_bank_q]) * PAY_WORDS - 1));

  // Output FSM next state. Word 0 is read while D1 is presented and each
  // accepted payload word fetches the next one, so rd_data_q only changes
  // on a transfer and stays stable during a stall.
  always_comb begin
    out_st_d   = out_st_q;
    out_bank_d = out_bank_q;
    rd_idx_d   = rd_idx_q;
    rd_en      = 1'b0;
    rd_addr    = {out_bank_q, rd_idx_q + 1'b1};
    rel        = 1'b0;
    case (out_st_q)
      OUT_IDLE: if (owned_q[out_bank_q]) out_st_d = OUT_D0;
      OUT_D0:   if (out_rdy) out_st_d = OUT_D1;
      OUT_D1: begin
        rd_en   = 1'b1;
        rd_addr = {out_bank_q, {ADDR_W{1'b0}}};
        if (out_rdy) begin
          out_st_d = OUT_PAY;
          rd_idx_d = '0;
        end
      end
      OUT_PAY: begin
        if (out_rdy) begin
          if (pay_last) begin
            out_st_d   = OUT_IDLE;
            rel        = 1'b1;
            out_bank_d = ~out_bank_q;
          end else begin
            rd_en    = 1'b1;
            rd_idx_d = rd_idx_q + 1'b1;
          end
        end
      end
      default: out_st_d = OUT_IDLE;
    endcase
  end

  // Output FSM outputs
  always_comb begin
    out_valid = (out_st_q != OUT_IDLE);
    out_sof   = (out_st_q == OUT_D0);
    out_eof   = (out_st_q == OUT_PAY) && pay_last;
    case (out_st_q)
      OUT_D0:  out_data = {dgbe_q[out_bank_q], 4'b0, ts_q[out_bank_q], dport_q[out_bank_q]};
      OUT_D1:  out_data = dip_q[out_bank_q];
      OUT_PAY: out_data = rd_data_q;
      default: out_data = '0;
    endcase
  end

  assign drop_cnt = drop_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_ts_rec_frame_aggr.sv
// tb_ts_rec_frame_aggr
//   Directed bench for ts_rec_frame_aggr: a table of single-destination
//   frames, then hand-written sequences for destination change + timeout,
//   bank exhaustion with drop, record abort, random backpressure and reset
//   mid-output.
module tb_ts_rec_frame_aggr;
  localparam int PAY_WORDS = 47;
  localparam int TIMEOUT   = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_din_en = 1'b0;
  logic [32:0] rec_din = '0;
  logic        out_rdy = 1'b1;
  logic        out_valid, out_sof, out_eof;
  logic [31:0] out_data;
  logic [15:0] drop_cnt, err_cnt;

  ts_rec_frame_aggr #(
    .TS_PER_FRAME(7), .PAY_WORDS(PAY_WORDS), .TIMEOUT(TIMEOUT), .ADDR_W(9)
  ) dut (
    .clk(clk), .rst(rst), .rec_din_en(rec_din_en), .rec_din(rec_din),
    .out_rdy(out_rdy), .out_valid(out_valid), .out_data(out_data),
    .out_sof(out_sof), .out_eof(out_eof), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  gbe;
    logic [31:0] ip;
    logic [15:0] port;
    int          n_rec;
    logic [31:0] exp_d0;
  } vec_t;

  vec_t        vec [4];
  logic [33:0] exp_q [$];
  int          checks = 0, failures = 0;
  int          cyc = 0, frames_seen = 0, words_seen = 0, sof_cyc = 0;
  bit          mon_en = 1'b0, prev_stall = 1'b0, rand_rdy = 1'b0;
  logic [33:0] prev_w = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Scoreboard: every accepted word is popped from exp_q and compared;
  // a stalled word must be presented unchanged on the next cycle.
  task automatic mon();
    logic [33:0] got_w, w;
    got_w = {out_eof, out_sof, out_data};
    if (!mon_en) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", 64'({out_valid, got_w}), 64'({1'b1, prev_w}));
      if (out_valid && out_rdy) begin
        words_seen++;
        if (out_sof) sof_cyc = cyc;
        if (out_eof) frames_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word got=%0h want=none", got_w);
        end else begin
          w = exp_q.pop_front();
          chk("out_word", 64'(got_w), 64'(w));
        end
      end
      prev_stall = out_valid && !out_rdy;
      prev_w     = got_w;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic put(input logic s, input logic [31:0] w);
    rec_din_en = 1'b1;
    rec_din    = {s, w};
    tick();
    rec_din_en = 1'b0;
    rec_din    = '0;
    if ($urandom_range(0, 3) == 0) tick();
  endtask

  task automatic send_rec(input logic [7:0] gbe, input logic [31:0] ip,
                          input logic [15:0] port, input logic [15:0] id,
                          input int abort_at);
    put(1'b1, {16'h0, id});
    put(1'b0, {24'h0, gbe});
    put(1'b0, ip);
    put(1'b0, {16'h0, port});
    for (int p = 0; p < PAY_WORDS; p++) begin
      if (p == abort_at) break;
      put(1'b0, {id, 16'(p)});
    end
  endtask

  task automatic send_group(input logic [7:0] gbe, input logic [31:0] ip,
                            input logic [15:0] port, input logic [15:0] id0, input int n);
    for (int r = 0; r < n; r++) send_rec(gbe, ip, port, id0 + 16'(r), -1);
  endtask

  task automatic push_frame(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [15:0] id0, input int n);
    exp_q.push_back({2'b01, d0});
    exp_q.push_back({2'b00, d1});
    for (int r = 0; r < n; r++)
      for (int p = 0; p < PAY_WORDS; p++)
        exp_q.push_back({(r == n - 1) && (p == PAY_WORDS - 1), 1'b0, id0 + 16'(r), 16'(p)});
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (frames_seen < target && n < budget) begin
      if (rand_rdy) out_rdy = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    out_rdy = 1'b1;
    chk(name, 64'(frames_seen), 64'(target));
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  initial begin
    int t_end, dly, w0, n;
    vec[0] = '{8'h01, 32'hC0A80001, 16'h04D2, 7, 32'h010704D2};
    vec[1] = '{8'hA5, 32'h0A000002, 16'h0050, 7, 32'hA5070050};
    vec[2] = '{8'h3C, 32'hFFFFFFFF, 16'hFFFF, 2, 32'h3C02FFFF};
    vec[3] = '{8'h00, 32'h00000000, 16'h0000, 1, 32'h00010000};

    // reset state
    tick();
    tick();
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_sof",   64'(out_sof),   64'(0));
    chk("rst_eof",   64'(out_eof),   64'(0));
    chk("rst_data",  64'(out_data),  64'(0));
    chk("rst_drop",  64'(drop_cnt),  64'(0));
    chk("rst_err",   64'(err_cnt),   64'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    // table: one destination per row, closed by count or by timeout
    for (int i = 0; i < 4; i++) begin
      push_frame(vec[i].exp_d0, vec[i].ip, 16'(16'h0100 + 16 * i), vec[i].n_rec);
      send_group(vec[i].gbe, vec[i].ip, vec[i].port, 16'(16'h0100 + 16 * i), vec[i].n_rec);
      wait_frames(frames_seen + 1, TIMEOUT + 1000, "tbl_frame");
      chk("tbl_drained", 64'(exp_q.size()), 64'(0));
    end

    // destination change closes A at once; B waits for the timeout
    push_frame(32'h11031111, 32'h11111111, 16'h0200, 3);
    push_frame(32'h22012222, 32'h22222222, 16'h0210, 1);
    send_group(8'h11, 32'h11111111, 16'h1111, 16'h0200, 3);
    send_group(8'h22, 32'h22222222, 16'h2222, 16'h0210, 1);
    t_end = cyc;
    wait_frames(frames_seen + 1, 400, "dest_change_frame");
    wait_frames(frames_seen + 1, TIMEOUT + 400, "timeout_frame");
    dly = sof_cyc - t_end;
    chk("timeout_delay_in_window", 64'((dly >= TIMEOUT - 2) && (dly <= TIMEOUT + 4)), 64'(1));

    // both banks held by a stalled output: 15th record is dropped
    do_reset();
    out_rdy = 1'b0;
    push_frame(32'h0A070A0A, 32'h0A0A0A0A, 16'h0300, 7);
    push_frame(32'h0B070B0B, 32'h0B0B0B0B, 16'h0310, 7);
    send_group(8'h0A, 32'h0A0A0A0A, 16'h0A0A, 16'h0300, 7);
    send_group(8'h0B, 32'h0B0B0B0B, 16'h0B0B, 16'h0310, 7);
    send_group(8'h0C, 32'h0C0C0C0C, 16'h0C0C, 16'h0320, 1);
    chk("drop_cnt_one", 64'(drop_cnt), 64'(1));
    chk("stalled_on_d0", 64'({out_valid, out_sof}), 64'(2'b11));
    out_rdy = 1'b1;
    wait_frames(frames_seen + 2, 1500, "stall_two_frames");
    chk("stall_drained", 64'(exp_q.size()), 64'(0));

    // stray idle word and an aborted record
    do_reset();
    put(1'b0, 32'hDEAD0000);
    send_rec(8'h5A, 32'h5A5A0001, 16'h1234, 16'h0400, 20);
    push_frame(32'h5A011234, 32'h5A5A0001, 16'h0401, 1);
    send_rec(8'h5A, 32'h5A5A0001, 16'h1234, 16'h0401, -1);
    chk("err_cnt_two", 64'(err_cnt), 64'(2));
    wait_frames(frames_seen + 1, TIMEOUT + 400, "abort_frame");
    chk("abort_drop_zero", 64'(drop_cnt), 64'(0));

    // random backpressure: exact word count, stability checked by mon()
    push_frame(32'h77070777, 32'h77777777, 16'h0500, 7);
    send_group(8'h77, 32'h77777777, 16'h0777, 16'h0500, 7);
    w0 = words_seen;
    rand_rdy = 1'b1;
    wait_frames(frames_seen + 1, 3000, "rand_rdy_frame");
    rand_rdy = 1'b0;
    chk("rand_word_count", 64'(words_seen - w0), 64'(331));

    // reset mid-output, then a fresh frame
    push_frame(32'hE107E1E1, 32'hE1E1E1E1, 16'h0600, 7);
    w0 = words_seen;
    send_group(8'hE1, 32'hE1E1E1E1, 16'hE1E1, 16'h0600, 7);
    n = 0;
    while (words_seen < w0 + 30 && n < 1000) begin
      tick();
      n++;
    end
    chk("mid_output_reached", 64'(words_seen >= w0 + 30), 64'(1));
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    chk("mrst_valid", 64'(out_valid), 64'(0));
    chk("mrst_sof",   64'(out_sof),   64'(0));
    chk("mrst_eof",   64'(out_eof),   64'(0));
    chk("mrst_data",  64'(out_data),  64'(0));
    chk("mrst_drop",  64'(drop_cnt),  64'(0));
    chk("mrst_err",   64'(err_cnt),   64'(0));
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    push_frame(32'hE207E2E2, 32'hE2E2E2E2, 16'h0700, 7);
    send_group(8'hE2, 32'hE2E2E2E2, 16'hE2E2, 16'h0700, 7);
    wait_frames(frames_seen + 1, 1500, "post_reset_frame");

    for (int i = 0; i < 20; i++) tick();
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
